dot_product_stream: RTL and testbench

//  Streaming dot-product engine, parametrised in vector length, sample width and signedness.

---
 rtl/dot_product_stream_if.sv | 23 ++
 rtl/dot_product_stream.sv | 146 ++++++++++++++
 tb/tb_dot_product_stream.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_stream_if.sv
// Valid/ready sample input and result output of the streaming dot-product engine.
// The slave side is the engine; the master side is the sample source and result sink.
interface dot_product_stream_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dot_product_stream.sv
// Streaming dot-product engine: takes VEC_LEN A samples then VEC_LEN B samples and
// returns sum(A[i]*B[i]) on a registered output that holds under backpressure.
module dot_product_stream #(
    parameter int DATA_W  = 8,
    parameter int VEC_LEN = 3,
    parameter int SIGNED  = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    dot_product_stream_if.slave  bus,
    output logic                 busy
);
    localparam int ACC_W  = 2 * DATA_W + $clog2(VEC_LEN);
    localparam int IDX_W  = $clog2(VEC_LEN);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(VEC_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [ACC_W-1:0]  ACC_ZERO = {ACC_W{1'b0}};

    typedef enum logic [0:0] {
        LOAD_A = 1'b0,
        LOAD_B = 1'b1
    } phase_t;

    // Full-width product, extended to ACC_W according to operand signedness.
    function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic signed [PROD_W-1:0] prod_signed;
        logic        [PROD_W-1:0] prod_unsigned;
        prod_signed   = PROD_W'($signed(a)) * PROD_W'($signed(b));
        prod_unsigned = PROD_W'(a) * PROD_W'(b);
        if (SIGNED != 0) begin
            mul_ext = {{(ACC_W - PROD_W){prod_signed[PROD_W-1]}}, prod_signed};
        end else begin
            mul_ext = {{(ACC_W - PROD_W){1'b0}}, prod_unsigned};
        end
    endfunction

    phase_t             phase_r, phase_n;
    logic [IDX_W-1:0]   idx_r, idx_n;
    logic [DATA_W-1:0]  a_mem_r [VEC_LEN];
    logic [ACC_W-1:0]   acc_r, acc_n;
    logic               out_valid_r, out_valid_n;
    logic [ACC_W-1:0]   out_data_r, out_data_n;
    logic               busy_r, busy_n;
    logic               last_s, in_ready_s, accept_s, load_a_s;
    logic [ACC_W-1:0]   sum_s;

    // Handshake qualification and running sum including the current B sample.
    always_comb begin
        last_s     = (idx_r == LAST_IDX);
        // Only the completing B sample waits for the output register to free up.
        in_ready_s = !flush && !((phase_r == LOAD_B) && last_s && out_valid_r && !bus.out_ready);
        accept_s   = bus.in_valid && in_ready_s;
        sum_s      = acc_r + mul_ext(a_mem_r[idx_r], bus.in_data);
    end

    // Next-state logic for phase, index, accumulator and result register.
    always_comb begin
        phase_n     = phase_r;
        idx_n       = idx_r;
        acc_n       = acc_r;
        load_a_s    = 1'b0;
        out_data_n  = out_data_r;
        if (bus.out_ready) begin
            out_valid_n = 1'b0;
        end else begin
            out_valid_n = out_valid_r;
        end
        if (flush) begin
            phase_n = LOAD_A;
            idx_n   = IDX_ZERO;
            acc_n   = ACC_ZERO;
        end else if (accept_s) begin
            case (phase_r)
                LOAD_A: begin
                    load_a_s = 1'b1;
                    if (last_s) begin
                        idx_n   = IDX_ZERO;
                        phase_n = LOAD_B;
                        acc_n   = ACC_ZERO;
                    end else begin
                        idx_n = idx_r + IDX_ONE;
                    end
                end
                LOAD_B: begin
                    if (last_s) begin
                        out_valid_n = 1'b1;
                        out_data_n  = sum_s;
                        acc_n       = ACC_ZERO;
                        idx_n       = IDX_ZERO;
                        phase_n     = LOAD_A;
                    end else begin
                        acc_n = sum_s;
                        idx_n = idx_r + IDX_ONE;
                    end
                end
                default: begin
                    phase_n = LOAD_A;
                    idx_n   = IDX_ZERO;
                    acc_n   = ACC_ZERO;
                end
            endcase
        end else begin
            load_a_s = 1'b0;
        end
        busy_n = (phase_n == LOAD_B) || (idx_n != IDX_ZERO);
    end

    // Control and result registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase_r     <= LOAD_A;
            idx_r       <= IDX_ZERO;
            acc_r       <= ACC_ZERO;
            out_valid_r <= 1'b0;
            out_data_r  <= ACC_ZERO;
            busy_r      <= 1'b0;
        end else begin
            phase_r     <= phase_n;
            idx_r       <= idx_n;
            acc_r       <= acc_n;
            out_valid_r <= out_valid_n;
            out_data_r  <= out_data_n;
            busy_r      <= busy_n;
        end
    end

    // A-vector buffer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                a_mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (load_a_s) begin
            a_mem_r[idx_r] <= bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign busy          = busy_r;
endmodule

// File: tb/tb_dot_product_stream.sv
// Bench for dot_product_stream: three configurations share one stimulus stream and are
// each checked every cycle against a list-of-samples reference model.
module tb_dot_product_stream;
    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, out_ready;
    logic [11:0] din;
    logic        ir [3];
    logic        ov [3];
    logic        bz [3];
    logic [31:0] od [3];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          nres0 = 0;
    bit          armed = 1'b0;
    bit          acc0 = 1'b0;
    int          smp [3][16];
    int          len [3];
    bit          pend [3];
    logic [31:0] pval [3];
    logic [31:0] got0 [$];
    logic [31:0] got1 [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DW = (g == 2) ? 12 : 8;
        localparam int VL = (g == 2) ? 8 : 3;
        localparam int SG = (g == 0) ? 0 : 1;
        localparam int AW = 2 * DW + $clog2(VL);
        dot_product_stream_if #(.DATA_W(DW), .ACC_W(AW)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.in_data   = din[DW-1:0];
        assign bus.out_ready = out_ready;
        dot_product_stream #(.DATA_W(DW), .VEC_LEN(VL), .SIGNED(SG)) dut (
            .clk    (clk),
            .resetn (resetn),
            .flush  (flush),
            .bus    (bus.slave),
            .busy   (bz[g])
        );
        assign ir[g] = bus.in_ready;
        assign ov[g] = bus.out_valid;
        assign od[g] = 32'(bus.out_data);
    end

    function automatic int dw_of(input int k); return (k == 2) ? 12 : 8; endfunction
    function automatic int vl_of(input int k); return (k == 2) ? 8 : 3; endfunction
    function automatic int sg_of(input int k); return (k == 0) ? 0 : 1; endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Dot product of the collected A and B samples, truncated to the result width.
    function automatic logic [31:0] dot_ref(input int k);
        longint s, a, b;
        int     v, dw, aw;
        v = vl_of(k); dw = dw_of(k); aw = 2 * dw + $clog2(v); s = 0;
        for (int i = 0; i < v; i++) begin
            a = smp[k][i];
            b = smp[k][v + i];
            if (sg_of(k) != 0) begin
                if (a >= (longint'(1) << (dw - 1))) a -= longint'(1) << dw;
                if (b >= (longint'(1) << (dw - 1))) b -= longint'(1) << dw;
            end
            s += a * b;
        end
        return 32'(s & ((longint'(1) << aw) - 1));
    endfunction

    task automatic model_cycle(input int k);
        int v;
        bit exp_ir, consumed, newres;
        v = vl_of(k);
        exp_ir = !flush && !((len[k] == 2 * v - 1) && pend[k] && !out_ready);
        if (armed) begin
            chk($sformatf("dut%0d_in_ready", k), ir[k], exp_ir);
            chk($sformatf("dut%0d_out_valid", k), ov[k], pend[k]);
            chk($sformatf("dut%0d_out_data", k), od[k], pval[k]);
            chk($sformatf("dut%0d_busy", k), bz[k], len[k] != 0);
        end
        if (k == 0) acc0 = resetn && in_valid && exp_ir;
        if (!resetn) begin
            len[k] = 0; pend[k] = 1'b0; pval[k] = 32'd0;
        end else begin
            consumed = pend[k] && out_ready;
            newres = 1'b0;
            if (flush) begin
                len[k] = 0;
            end else if (in_valid && exp_ir) begin
                smp[k][len[k]] = int'(din) & ((1 << dw_of(k)) - 1);
                len[k]++;
                if (len[k] == 2 * v) begin
                    pval[k] = dot_ref(k); newres = 1'b1; len[k] = 0;
                    if (k == 0) nres0++;
                end
            end
            if (newres) pend[k] = 1'b1;
            else if (consumed) pend[k] = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (resetn === 1'b1 && out_ready && ov[0] === 1'b1) got0.push_back(od[0]);
        if (resetn === 1'b1 && out_ready && ov[1] === 1'b1) got1.push_back(od[1]);
        for (int k = 0; k < 3; k++) model_cycle(k);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [11:0] v);
        int guard;
        in_valid = 1'b1; din = v; guard = 0; acc0 = 1'b0;
        while (!acc0 && guard < 50) begin
            tick();
            guard++;
        end
        chk("send_accept", acc0, 1'b1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic expect_pop(input string tag, input int which, input logic [31:0] exp);
        logic [31:0] v;
        v = 32'hFFFF_FFFF;
        if (which == 0) begin
            if (got0.size() > 0) v = got0.pop_front();
        end else begin
            if (got1.size() > 0) v = got1.pop_front();
        end
        chk(tag, v, exp);
    endtask

    initial begin
        int t0, guard;
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din = 12'd0;
        tick();
        armed = 1'b1;
        tick();
        chk("reset_out_valid", ov[0], 1'b0);
        chk("reset_out_data", od[0], 32'd0);
        chk("reset_busy", bz[0], 1'b0);
        resetn = 1'b1;
        tick();

        // Basic op and latency from first accept to out_valid.
        send(12'd1); t0 = cyc - 1;
        send(12'd2); send(12'd3); send(12'd4); send(12'd5); send(12'd6);
        in_valid = 1'b0; guard = 0;
        while (ov[0] !== 1'b1 && guard < 20) begin tick(); guard++; end
        chk("t1_latency", cyc - t0, 6);
        chk("t1_result_u", od[0], 32'd32);
        chk("t1_result_s", od[1], 32'd32);
        idle(3);
        got0.delete(); got1.delete();

        // Maximum unsigned operands, then a back-to-back second op.
        t0 = cyc;
        repeat (6) send(12'h0FF);
        send(12'd0); send(12'd0); send(12'd1); send(12'd0); send(12'd0); send(12'd7);
        chk("t2_no_idle", cyc - t0, 12);
        idle(3);
        expect_pop("t2_max_u", 0, 32'h2FA03);
        expect_pop("t2_b2b_u", 0, 32'd7);
        expect_pop("t2_max_s", 1, 32'd3);
        expect_pop("t2_b2b_s", 1, 32'd7);

        // Mixed-sign operands and most-negative operands.
        send(12'd127); send(12'h0FF); send(12'd2); send(12'h0FE); send(12'd3); send(12'd5);
        repeat (6) send(12'h080);
        idle(3);
        expect_pop("t3_mixed_u", 0, 32'd33033);
        expect_pop("t3_mixed_s", 1, 32'h3FF09);
        expect_pop("t3_neg_u", 0, 32'd49152);
        expect_pop("t3_neg_s", 1, 32'd49152);
        got0.delete(); got1.delete();

        // Backpressure: only the completing B sample stalls.
        out_ready = 1'b0;
        send(12'd1); send(12'd2); send(12'd3); send(12'd4); send(12'd5); send(12'd6);
        t0 = cyc;
        repeat (5) send(12'd1);
        chk("t4_flow", cyc - t0, 5);
        in_valid = 1'b1; din = 12'd1;
        repeat (3) begin
            tick();
            chk("t4_stall", acc0, 1'b0);
            chk("t4_hold", od[0], 32'd32);
        end
        out_ready = 1'b1;
        tick();
        chk("t4_release_accept", acc0, 1'b1);
        chk("t4_new_result", od[0], 32'd3);
        chk("t4_valid_kept", ov[0], 1'b1);
        idle(2);
        expect_pop("t4_first", 0, 32'd32);
        expect_pop("t4_second", 0, 32'd3);
        chk("t4_count", got0.size(), 0);
        got1.delete();

        // Flush of a partial op; the flush-cycle sample is dropped.
        send(12'd9); send(12'd9);
        flush = 1'b1; din = 12'd5;
        tick();
        chk("t5_flush_no_accept", acc0, 1'b0);
        chk("t5_flush_busy", bz[0], 1'b0);
        flush = 1'b0;
        send(12'd1); send(12'd2); send(12'd3); send(12'd4); send(12'd5); send(12'd6);
        idle(3);
        chk("t5_count", got0.size(), 1);
        expect_pop("t5_result", 0, 32'd32);

        // Random bubbles, backpressure, occasional flush and mid-op reset.
        t0 = nres0;
        for (int it = 0; it < 40000 && nres0 < t0 + 1000; it++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            din       = 12'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 299) == 0);
            if (it % 3001 == 1500) begin
                resetn = 1'b0;
                tick();
                for (int k = 0; k < 3; k++) chk($sformatf("t6_reset_dut%0d", k), ov[k], 1'b0);
                resetn = 1'b1;
            end else begin
                tick();
            end
        end
        chk("t6_ops", nres0 >= t0 + 1000, 1'b1);
        flush = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
